// File: rtl/reservation_station_mult_if.sv
// Bundles dispatch, CDB and issue signals between rename/dispatch, the multiply
// reservation station and the multiplier issue stage.
interface reservation_station_mult_if #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
);
    logic                  dispatchValid_i;
    logic [9:0]            dispatchCommands_i;
    logic [ROBsizeLog-1:0] dispatchTag_i;
    logic [63:0]           dispatchVal1_i;
    logic [63:0]           dispatchVal2_i;
    logic                  dispatchRdy1_i;
    logic                  dispatchRdy2_i;
    logic [ROBsizeLog-1:0] dispatchSrc1_i;
    logic [ROBsizeLog-1:0] dispatchSrc2_i;
    logic                  rsFull_o;

    logic                  cdbValid_i;
    logic [ROBsizeLog-1:0] cdbTag_i;
    logic [63:0]           cdbVal_i;

    logic                  readyRS_o;
    logic [63:0]           reservationStationVal1_o;
    logic [63:0]           reservationStationVal2_o;
    logic [9:0]            reservationStationCommands_o;
    logic [ROBsizeLog-1:0] reservationStationTag_o;
    logic                  stallRS_i;

    modport master (
        output dispatchValid_i, dispatchCommands_i, dispatchTag_i,
        output dispatchVal1_i, dispatchVal2_i, dispatchRdy1_i, dispatchRdy2_i,
        output dispatchSrc1_i, dispatchSrc2_i,
        output cdbValid_i, cdbTag_i, cdbVal_i, stallRS_i,
        input  rsFull_o, readyRS_o, reservationStationVal1_o, reservationStationVal2_o,
        input  reservationStationCommands_o, reservationStationTag_o
    );

    modport slave (
        input  dispatchValid_i, dispatchCommands_i, dispatchTag_i,
        input  dispatchVal1_i, dispatchVal2_i, dispatchRdy1_i, dispatchRdy2_i,
        input  dispatchSrc1_i, dispatchSrc2_i,
        input  cdbValid_i, cdbTag_i, cdbVal_i, stallRS_i,
        output rsFull_o, readyRS_o, reservationStationVal1_o, reservationStationVal2_o,
        output reservationStationCommands_o, reservationStationTag_o
    );
endinterface

// File: rtl/reservation_station_mult.sv
// Multiply reservation station: holds dispatched ops, captures operands off the CDB.
// Latency: dispatch or wakeup at edge N -> eligible for issue in cycle N+1 (no bypass).
// Backpressure: issue holds while stallRS_i=1; dispatch is dropped while rsFull_o=1.
module reservation_station_mult #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int RSsize     = 4
) (
    input logic                       clk_i,
    input logic                       reset_i,
    input logic                       flush_i,
    reservation_station_mult_if.slave rs
);
    localparam int IW = (RSsize > 1) ? $clog2(RSsize) : 1;

    typedef struct packed {
        logic                  vld;
        logic [9:0]            cmd;
        logic [ROBsizeLog-1:0] tag;
        logic [63:0]           val1;
        logic                  rdy1;
        logic [ROBsizeLog-1:0] src1;
        logic [63:0]           val2;
        logic                  rdy2;
        logic [ROBsizeLog-1:0] src2;
    } entry_t;

    entry_t ent_q [RSsize];
    entry_t ent_d [RSsize];
    entry_t new_ent;

    logic [RSsize-1:0] vld_vec;
    logic [RSsize-1:0] rdy_vec;
    logic [IW-1:0]     sel_idx;
    logic [IW-1:0]     free_idx;
    logic              any_rdy;
    logic              full;
    logic              issue_fire;
    logic              disp_fire;

    always_comb begin
        for (int i = 0; i < RSsize; i++) begin
            vld_vec[i] = ent_q[i].vld;
            rdy_vec[i] = ent_q[i].vld & ent_q[i].rdy1 & ent_q[i].rdy2;
        end
    end

    // Priority pickers scan downward so the lowest index wins; both use registered state only.
    always_comb begin
        sel_idx  = '0;
        free_idx = '0;
        for (int i = RSsize - 1; i >= 0; i--) begin
            if (rdy_vec[i])  sel_idx  = IW'(i);
            if (!vld_vec[i]) free_idx = IW'(i);
        end
    end

    assign any_rdy    = |rdy_vec;
    assign full       = &vld_vec;
    assign issue_fire = any_rdy & ~rs.stallRS_i;
    assign disp_fire  = rs.dispatchValid_i & ~full;

    always_comb begin
        new_ent      = '0;
        new_ent.vld  = 1'b1;
        new_ent.cmd  = rs.dispatchCommands_i;
        new_ent.tag  = rs.dispatchTag_i;
        new_ent.val1 = rs.dispatchVal1_i;
        new_ent.rdy1 = rs.dispatchRdy1_i;
        new_ent.src1 = rs.dispatchSrc1_i;
        new_ent.val2 = rs.dispatchVal2_i;
        new_ent.rdy2 = rs.dispatchRdy2_i;
        new_ent.src2 = rs.dispatchSrc2_i;
        // Producer broadcasting in the dispatch cycle would otherwise be missed.
        if (!rs.dispatchRdy1_i && rs.cdbValid_i && rs.dispatchSrc1_i == rs.cdbTag_i) begin
            new_ent.val1 = rs.cdbVal_i;
            new_ent.rdy1 = 1'b1;
        end
        if (!rs.dispatchRdy2_i && rs.cdbValid_i && rs.dispatchSrc2_i == rs.cdbTag_i) begin
            new_ent.val2 = rs.cdbVal_i;
            new_ent.rdy2 = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < RSsize; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].vld && rs.cdbValid_i) begin
                if (!ent_q[i].rdy1 && ent_q[i].src1 == rs.cdbTag_i) begin
                    ent_d[i].val1 = rs.cdbVal_i;
                    ent_d[i].rdy1 = 1'b1;
                end
                if (!ent_q[i].rdy2 && ent_q[i].src2 == rs.cdbTag_i) begin
                    ent_d[i].val2 = rs.cdbVal_i;
                    ent_d[i].rdy2 = 1'b1;
                end
            end
        end
        if (issue_fire) ent_d[sel_idx].vld = 1'b0;
        // free_idx points at a slot already empty, never the one being issued this cycle.
        if (disp_fire)  ent_d[free_idx]    = new_ent;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < RSsize; i++) ent_q[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RSsize; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < RSsize; i++) ent_q[i] <= ent_d[i];
        end
    end

    always_comb begin
        rs.readyRS_o                    = any_rdy;
        rs.rsFull_o                     = full;
        rs.reservationStationVal1_o     = '0;
        rs.reservationStationVal2_o     = '0;
        rs.reservationStationCommands_o = '0;
        rs.reservationStationTag_o      = '0;
        if (any_rdy) begin
            rs.reservationStationVal1_o     = ent_q[sel_idx].val1;
            rs.reservationStationVal2_o     = ent_q[sel_idx].val2;
            rs.reservationStationCommands_o = ent_q[sel_idx].cmd;
            rs.reservationStationTag_o      = ent_q[sel_idx].tag;
        end
    end
endmodule

// File: tb/tb_reservation_station_mult.sv
// Self-checking bench: directed vector table, hand sequences for reset/flush,
// then randomized traffic against a slot-level reference model.
module tb_reservation_station_mult;
    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    logic flush_i = 1'b0;

    always #5 clk_i = ~clk_i;

    reservation_station_mult_if #(.ROBsize(32)) bus ();

    reservation_station_mult #(.ROBsize(32), .RSsize(4)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .rs     (bus)
    );

    typedef struct {
        logic        dv;
        logic [5:0]  dtag;
        logic [9:0]  cmd;
        logic [63:0] d1, d2;
        logic        r1, r2;
        logic [5:0]  s1, s2;
        logic        cv;
        logic [5:0]  ctag;
        logic [63:0] cval;
        logic        stall;
        logic        flush;
        logic        e_rdy;
        logic [63:0] e_v1, e_v2;
        logic [5:0]  e_tag;
        logic        e_full;
    } vec_t;

    typedef struct {
        bit              live;
        logic [5:0]      tag;
        logic [9:0]      cmd;
        logic [1:0][63:0] val;
        logic [1:0]      have;
        logic [1:0][5:0] src;
    } op_t;

    int   n_cmp = 0;
    int   n_err = 0;
    op_t  m [4];
    vec_t tbl [$];

    function automatic vec_t mk(int dv, int dtag, int d1, int d2, int r1, int r2, int s1, int s2,
                                int cv, int ctag, int cval, int stall,
                                int er, int e1, int e2, int et, int ef);
        vec_t v;
        v.dv = 1'(dv);   v.dtag = 6'(dtag); v.cmd = {4'hA, 6'(dtag)};
        v.d1 = 64'(d1);  v.d2 = 64'(d2);    v.r1 = 1'(r1); v.r2 = 1'(r2);
        v.s1 = 6'(s1);   v.s2 = 6'(s2);
        v.cv = 1'(cv);   v.ctag = 6'(ctag); v.cval = 64'(cval);
        v.stall = 1'(stall); v.flush = 1'b0;
        v.e_rdy = 1'(er); v.e_v1 = 64'(e1); v.e_v2 = 64'(e2); v.e_tag = 6'(et); v.e_full = 1'(ef);
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic e_rdy, input logic [63:0] e1,
                              input logic [63:0] e2, input logic [5:0] et,
                              input logic [9:0] ec, input logic ef);
        check({nm, ".readyRS"}, 64'(bus.readyRS_o), 64'(e_rdy));
        check({nm, ".val1"},    bus.reservationStationVal1_o, e1);
        check({nm, ".val2"},    bus.reservationStationVal2_o, e2);
        check({nm, ".tag"},     64'(bus.reservationStationTag_o), 64'(et));
        check({nm, ".cmd"},     64'(bus.reservationStationCommands_o), 64'(ec));
        check({nm, ".rsFull"},  64'(bus.rsFull_o), 64'(ef));
    endtask

    task automatic drive_vec(input vec_t v);
        bus.dispatchValid_i    = v.dv;
        bus.dispatchTag_i      = v.dtag;
        bus.dispatchCommands_i = v.cmd;
        bus.dispatchVal1_i     = v.d1;
        bus.dispatchVal2_i     = v.d2;
        bus.dispatchRdy1_i     = v.r1;
        bus.dispatchRdy2_i     = v.r2;
        bus.dispatchSrc1_i     = v.s1;
        bus.dispatchSrc2_i     = v.s2;
        bus.cdbValid_i         = v.cv;
        bus.cdbTag_i           = v.ctag;
        bus.cdbVal_i           = v.cval;
        bus.stallRS_i          = v.stall;
        flush_i                = v.flush;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply(input vec_t v, input string nm);
        drive_vec(v);
        tick();
        check_outs(nm, v.e_rdy, v.e_v1, v.e_v2, v.e_tag,
                   v.e_rdy ? {4'hA, v.e_tag} : 10'd0, v.e_full);
    endtask

    // Reference model: ops live in numbered slots; oldest-lowest-slot fully-ready op issues.
    function automatic int m_pick();
        for (int i = 0; i < 4; i++)
            if (m[i].live && m[i].have == 2'b11) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m[i].live = 1'b0;
    endtask

    task automatic m_step(input vec_t v);
        int  pick;
        int  slot;
        bit  full;
        op_t n;
        pick = m_pick();
        slot = -1;
        full = 1'b1;
        for (int i = 0; i < 4; i++)
            if (!m[i].live) begin
                full = 1'b0;
                if (slot < 0) slot = i;
            end
        if (v.flush) begin
            m_clear();
            return;
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 2; k++)
                if (m[i].live && !m[i].have[k] && v.cv && m[i].src[k] == v.ctag) begin
                    m[i].val[k]  = v.cval;
                    m[i].have[k] = 1'b1;
                end
        if (pick >= 0 && !v.stall) m[pick].live = 1'b0;
        if (v.dv && !full) begin
            n.live = 1'b1;
            n.tag  = v.dtag;
            n.cmd  = v.cmd;
            n.val  = {v.d2, v.d1};
            n.have = {v.r2, v.r1};
            n.src  = {v.s2, v.s1};
            for (int k = 0; k < 2; k++)
                if (!n.have[k] && v.cv && n.src[k] == v.ctag) begin
                    n.val[k]  = v.cval;
                    n.have[k] = 1'b1;
                end
            m[slot] = n;
        end
    endtask

    task automatic m_compare(input string nm);
        int p;
        bit full;
        p    = m_pick();
        full = m[0].live && m[1].live && m[2].live && m[3].live;
        if (p >= 0)
            check_outs(nm, 1'b1, m[p].val[0], m[p].val[1], m[p].tag, m[p].cmd, full);
        else
            check_outs(nm, 1'b0, 64'd0, 64'd0, 6'd0, 10'd0, full);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0, 0,0,0, 0, 0,0,0,0,0);
        drive_vec(idle);
        #1;
        check_outs("reset", 1'b0, 64'd0, 64'd0, 6'd0, 10'd0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b1;

        // dv,dtag,d1,d2,r1,r2,s1,s2, cv,ctag,cval, stall, exp rdy,v1,v2,tag,full
        tbl.push_back(mk(1, 7, 3, 5, 1,1, 0, 0,  0, 0, 0,      1,  1, 3, 5, 7, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  0, 0, 0,      0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1,10, 0, 2, 0,1, 9, 0,  1, 9,'h1234,  1,  1,'h1234, 2, 10, 0));
        tbl.push_back(mk(1,11, 0, 0, 0,0,12,13,  0, 0, 0,      0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  1,12,'h55,    1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  1,13,'h66,    1,  1,'h55,'h66, 11, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  0, 0, 0,      0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1,14, 0, 0, 0,0,20,20,  0, 0, 0,      1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  1,20,'h77,    1,  1,'h77,'h77, 14, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  0, 0, 0,      0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1,11, 1,1, 0, 0,  0, 0, 0,      1,  1, 1,11, 1, 0));
        tbl.push_back(mk(1, 2, 2,12, 1,1, 0, 0,  0, 0, 0,      1,  1, 1,11, 1, 0));
        tbl.push_back(mk(1, 3, 3,13, 1,1, 0, 0,  0, 0, 0,      1,  1, 1,11, 1, 0));
        tbl.push_back(mk(1, 4, 4,14, 1,1, 0, 0,  0, 0, 0,      1,  1, 1,11, 1, 1));
        tbl.push_back(mk(1, 5, 5,15, 1,1, 0, 0,  0, 0, 0,      1,  1, 1,11, 1, 1));
        tbl.push_back(mk(1, 6, 6,16, 1,1, 0, 0,  0, 0, 0,      0,  1, 2,12, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  0, 0, 0,      0,  1, 3,13, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  0, 0, 0,      0,  1, 4,14, 4, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,0, 0, 0,  0, 0, 0,      0,  0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset with three ready entries held by stall
        apply(mk(1,21,21,31,1,1,0,0, 0,0,0, 1, 1,21,31,21,0), "rst_fill0");
        apply(mk(1,22,22,32,1,1,0,0, 0,0,0, 1, 1,21,31,21,0), "rst_fill1");
        apply(mk(1,23,23,33,1,1,0,0, 0,0,0, 1, 1,21,31,21,0), "rst_fill2");
        #2;
        reset_i = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 64'd0, 64'd0, 6'd0, 10'd0, 1'b0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        for (int i = 0; i < 3; i++) apply(idle, $sformatf("rst_after%0d", i));

        // Flush with coincident dispatch and CDB
        apply(mk(1,30, 0,2, 0,1, 40,0,  0,0,0, 1, 0,0,0,0,0), "fl_disp0");
        apply(mk(1,31, 3,0, 1,0, 0,41,  0,0,0, 1, 0,0,0,0,0), "fl_disp1");
        v = mk(1,32, 8,9, 1,1, 0,0,  1,40,9, 1, 0,0,0,0,0);
        v.flush = 1'b1;
        apply(v, "fl_flush");
        apply(mk(0,0,0,0,0,0,0,0, 1,40,'h99, 1, 0,0,0,0,0), "fl_cdb40");
        apply(mk(0,0,0,0,0,0,0,0, 1,41,'h98, 0, 0,0,0,0,0), "fl_cdb41");
        apply(mk(1,33,4,6, 1,1, 0,0, 0,0,0,   1, 1,4,6,33,0), "fl_reuse");
        apply(mk(0,0,0,0,0,0,0,0, 0,0,0,      0, 0,0,0,0,0), "fl_drain");

        // Randomized traffic against the reference model
        drive_vec(idle);
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        m_clear();
        m_compare("rnd_start");
        for (int c = 0; c < 400; c++) begin
            v       = idle;
            v.dv    = 1'($urandom_range(1, 0));
            v.dtag  = 6'($urandom);
            v.cmd   = 10'($urandom);
            v.d1    = {$urandom, $urandom};
            v.d2    = {$urandom, $urandom};
            v.r1    = 1'($urandom_range(1, 0));
            v.r2    = 1'($urandom_range(1, 0));
            v.s1    = 6'($urandom_range(7, 0));
            v.s2    = 6'($urandom_range(7, 0));
            v.cv    = ($urandom_range(4, 0) < 3);
            v.ctag  = 6'($urandom_range(7, 0));
            v.cval  = {$urandom, $urandom};
            v.stall = ($urandom_range(2, 0) == 0);
            v.flush = ($urandom_range(49, 0) == 0);
            drive_vec(v);
            m_step(v);
            tick();
            m_compare($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
